pattern_checker: RTL

//  Self-checking stimulus/response engine for combinational gate-level DUTs.
//  - Drives every switch vector onto the DUT inputs and holds it for a settle window.
//  - Compares DUT outputs against a golden-model output.
//  - Counts mismatches and reports pass/fail.
//  - Replaces the free-running pattern generator + passive monitor pair; synthesizable, so it can also run on-board.

---
 rtl/pattern_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pattern_checker.sv
// Stimulus/response checker: steps sw_out through every vector, holds each for SETTLE+1 cycles,
// compares dut_out against ref_out on the last hold cycle. Optional first-mismatch capture: PATCHK_FIRST_ERR_EN.
module pattern_checker #(
    parameter int SW_W   = 4,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 2,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] ref_out,
    output logic [SW_W-1:0]  sw_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
`ifdef PATCHK_FIRST_ERR_EN
    output logic [SW_W-1:0]  first_err_vec,
    output logic             first_err_vld,
`endif
    output logic [1:0]       fsm_state
);

    localparam int HOLD_W = $clog2(SETTLE + 1);
    localparam logic [HOLD_W-1:0] SETTLE_C = HOLD_W'(SETTLE);
    localparam logic [SW_W-1:0]   LAST_IDX = {SW_W{1'b1}};
    localparam logic [CNT_W-1:0]  ERR_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [SW_W-1:0]   idx, idx_n;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0]  err_n;
    logic [SW_W-1:0]   sw_n;
    logic              mismatch;
`ifdef PATCHK_FIRST_ERR_EN
    logic [SW_W-1:0]   first_vec_n;
    logic              first_vld_n;
`endif

    function automatic logic [SW_W-1:0] vec(input logic [SW_W-1:0] i);
        if (MODE == 1) return i ^ (i >> 1);
        else           return i;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            sw_out  <= '0;
`ifdef PATCHK_FIRST_ERR_EN
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            err_cnt <= err_n;
            sw_out  <= sw_n;
`ifdef PATCHK_FIRST_ERR_EN
            first_err_vec <= first_vec_n;
            first_err_vld <= first_vld_n;
`endif
        end
    end

    // Responses are only looked at on the compare edge, so X elsewhere is harmless.
    assign mismatch = (dut_out != ref_out);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        err_n   = err_cnt;
        sw_n    = sw_out;
`ifdef PATCHK_FIRST_ERR_EN
        first_vec_n = first_err_vec;
        first_vld_n = first_err_vld;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RUN;
                    idx_n   = '0;
                    cnt_n   = '0;
                    err_n   = '0;
                    sw_n    = vec('0);
`ifdef PATCHK_FIRST_ERR_EN
                    first_vec_n = '0;
                    first_vld_n = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (cnt != SETTLE_C) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    if (mismatch && (err_cnt != ERR_MAX)) err_n = err_cnt + 1'b1;
`ifdef PATCHK_FIRST_ERR_EN
                    if (mismatch && !first_err_vld) begin
                        first_vec_n = sw_out;
                        first_vld_n = 1'b1;
                    end
`endif
                    // Last vector: sw_out keeps showing it while results sit in DONE.
                    if (idx == LAST_IDX) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n = idx + 1'b1;
                        cnt_n = '0;
                        sw_n  = vec(idx + 1'b1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign pass      = (state == S_DONE) && (err_cnt == '0);
    assign fsm_state = state;

endmodule
